// File: rtl/fetch_seq_if.sv
// Bundle of the fetch sequencer's instruction-memory, downstream and branch
// signals. The fetch block takes the master side; memory, decode and
// branch-resolution logic (or a testbench) take the slave side.
interface fetch_seq_if;
    // Instruction-memory request channel
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // Downstream instruction channel
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    // Branch resolution feedback
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready,
        input  br_valid,
        input  br_taken,
        input  br_target
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready,
        output br_valid,
        output br_taken,
        output br_target
    );
endinterface

// File: rtl/fetch_seq.sv
// Instruction fetch sequencer.
// Issues one word-aligned fetch at a time, holds the returned instruction
// until downstream takes it, and follows taken branches. A redirect that
// arrives while a request is outstanding cannot move imem_addr (the request
// must stay stable until acked), so it is remembered in pend_pc and the kill
// flag marks the eventual returned word as stale.
module fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rstn,
    fetch_seq_if.master  bus,
    output logic [15:0]  redirect_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc;
    logic [31:0] pend_pc;
    logic        kill;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;

    logic        redirect;
    logic [31:0] target;
    logic        ack_keep;
    logic        ack_drop;
    logic        req_kill;
    logic        hold_redirect;
    logic        hold_advance;
    logic        cnt_inc;
    logic        unused_target_bits;

    // Branch decode: only a taken branch redirects, and targets are word aligned
    always_comb begin
        redirect           = bus.br_valid & bus.br_taken;
        target             = {bus.br_target[31:2], 2'b00};
        unused_target_bits = ^bus.br_target[1:0];
    end

    // Event decode for the datapath: which of the per-state actions fires now
    always_comb begin
        ack_keep      = 1'b0;
        ack_drop      = 1'b0;
        req_kill      = 1'b0;
        hold_redirect = 1'b0;
        hold_advance  = 1'b0;
        cnt_inc       = 1'b0;
        if (state == REQ) begin
            ack_keep = bus.imem_ack & ~kill & ~redirect;
            ack_drop = bus.imem_ack & (kill | redirect);
            req_kill = ~bus.imem_ack & redirect;
        end
        if (state == HOLD) begin
            hold_redirect = redirect;
            hold_advance  = ~redirect & bus.inst_ready;
        end
        if (state != IDLE) begin
            cnt_inc = redirect & (redirect_cnt != 16'hFFFF);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE is a single warm-up cycle; REQ only moves on
    // with usable data; HOLD leaves on consumption or redirect
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (ack_keep) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (hold_redirect || hold_advance) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // PC, kill/pending-redirect and captured-instruction registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pc        <= RESET_PC;
            pend_pc   <= 32'h0000_0000;
            kill      <= 1'b0;
            inst_q    <= 32'h0000_0000;
            inst_pc_q <= 32'h0000_0000;
        end else begin
            if (ack_keep) begin
                inst_q    <= bus.imem_rdata;
                inst_pc_q <= pc;
            end
            if (ack_drop) begin
                pc   <= redirect ? target : pend_pc;
                kill <= 1'b0;
            end
            if (req_kill) begin
                kill    <= 1'b1;
                pend_pc <= target;
            end
            if (hold_redirect) begin
                pc <= target;
            end else if (hold_advance) begin
                pc <= pc + 32'd4;
            end
        end
    end

    // Saturating count of taken redirects seen outside IDLE
    always_ff @(posedge clk) begin
        if (!rstn) begin
            redirect_cnt <= 16'h0000;
        end else if (cnt_inc) begin
            redirect_cnt <= redirect_cnt + 16'd1;
        end
    end

    // Outputs are decoded from state and registers only, so nothing here
    // depends combinationally on the handshake inputs
    always_comb begin
        bus.imem_req   = (state == REQ);
        bus.imem_addr  = pc;
        bus.inst_valid = (state == HOLD);
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
    end

endmodule

// File: tb/tb_fetch_seq.sv
// Self-checking bench for fetch_seq. Inputs change and outputs are sampled
// on the falling clock edge; instructions expected downstream are queued
// when memory returns non-discarded data and popped when offered.
module tb_fetch_seq;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] redirect_cnt;

    fetch_seq_if bus ();

    fetch_seq #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus),
        .redirect_cnt (redirect_cnt)
    );

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [31:0] pat(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive_idle();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.inst_ready = 1'b0;
        bus.br_valid   = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = 32'h0;
    endtask

    // Reset, release, and return on the first REQ cycle
    task automatic do_reset();
        rstn = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        @(negedge clk);
    endtask

    // From a REQ cycle, redirect with a same-cycle ack so pc lands on t
    task automatic jump_to(input logic [31:0] t);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        bus.br_valid   = 1'b1;
        bus.br_taken   = 1'b1;
        bus.br_target  = t;
        @(negedge clk);
        exp_cnt++;
        drive_idle();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'h1234_5678; bus.inst_ready = 1'b1;
        bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h40;
        repeat (3) @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req: got %0b want 0", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_imem_addr: got %h want 0", bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_inst_valid: got %0b want 0", bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h want 0", bus.inst); end
        checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst_pc: got %h want 0", bus.inst_pc); end
        checks++; if (redirect_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_cnt: got %h want 0", redirect_cnt); end
        rstn = 1'b1;
        drive_idle();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %0b want 1", bus.imem_req); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_addr: got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc = 32'h0;
        logic        want_req;
        int          nvalid = 0;
        exp_t        e;
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.inst_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            want_req = (c % 2 == 0);
            checks++; if (bus.imem_req !== want_req) begin errors++; $display("[TB] FAIL seq_req c=%0d: got %0b want %0b", c, bus.imem_req, want_req); end
            checks++; if (bus.inst_valid !== ~want_req) begin errors++; $display("[TB] FAIL seq_valid c=%0d: got %0b want %0b", c, bus.inst_valid, ~want_req); end
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== exp_pc) begin errors++; $display("[TB] FAIL seq_addr: got %h want %h", bus.imem_addr, exp_pc); end
                bus.imem_rdata = pat(exp_pc);
                exp_q.push_back('{inst: pat(exp_pc), pc: exp_pc});
                exp_pc += 32'd4;
            end
            if (bus.inst_valid === 1'b1) begin
                nvalid++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL seq_unexpected: inst_pc %h offered with nothing expected", bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.inst_pc !== e.pc || bus.inst !== e.inst) begin
                        errors++; $display("[TB] FAIL seq_inst: got %h@%h want %h@%h", bus.inst, bus.inst_pc, e.inst, e.pc);
                    end
                end
            end
            @(negedge clk);
        end
        checks++; if (nvalid != 3) begin errors++; $display("[TB] FAIL seq_count: got %0d want 3", nvalid); end
        drive_idle();
    endtask

    task automatic test_hold_stall();
        exp_t e;
        do_reset();
        jump_to(32'h10);
        checks++; if (bus.imem_addr !== 32'h10) begin errors++; $display("[TB] FAIL stall_addr: got %h want 10", bus.imem_addr); end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = pat(32'h10);
        exp_q.push_back('{inst: pat(32'h10), pc: 32'h10});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        e = exp_q[0];
        for (int c = 0; c < 4; c++) begin
            checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_valid c=%0d: got %0b want 1", c, bus.inst_valid); end
            checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req c=%0d: got %0b want 0", c, bus.imem_req); end
            checks++; if (bus.inst !== e.inst || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL stall_inst c=%0d: got %h@%h want %h@%h", c, bus.inst, bus.inst_pc, e.inst, e.pc); end
            bus.inst_ready = (c == 3);
            @(negedge clk);
        end
        void'(exp_q.pop_front());
        bus.inst_ready = 1'b0;
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL stall_next: got req=%0b addr=%h want req=1 addr=14", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL stall_after_valid: got %0b want 0", bus.inst_valid); end
        checks++; if (redirect_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL stall_cnt: got %0d want %0d", redirect_cnt, exp_cnt); end
    endtask

    task automatic test_redirect_req();
        exp_t e;
        do_reset();
        jump_to(32'h20);
        checks++; if (bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL rr_start_addr: got %h want 20", bus.imem_addr); end
        bus.imem_ack = 1'b0;
        bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h103;
        @(negedge clk);
        exp_cnt++;
        drive_idle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h20) begin errors++; $display("[TB] FAIL rr_hold_addr: got req=%0b addr=%h want req=1 addr=20", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_discard_valid: got %0b want 0", bus.inst_valid); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rr_new_addr: got req=%0b addr=%h want req=1 addr=100", bus.imem_req, bus.imem_addr); end
        checks++; if (redirect_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL rr_cnt: got %0d want %0d", redirect_cnt, exp_cnt); end
        // two redirects while stalled: the later target must win
        bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h300;
        @(negedge clk);
        bus.br_target = 32'h405;
        @(negedge clk);
        exp_cnt += 2;
        drive_idle();
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL rr_stalled_addr: got %h want 100", bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = 32'hBAD1_BAD1;
        @(negedge clk);
        checks++; if (bus.imem_addr !== 32'h404 || bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL rr_overwrite: got addr=%h valid=%0b want addr=404 valid=0", bus.imem_addr, bus.inst_valid); end
        bus.imem_rdata = pat(32'h404);
        exp_q.push_back('{inst: pat(32'h404), pc: 32'h404});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== e.inst || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL rr_fetch: got v=%0b %h@%h want v=1 %h@%h", bus.inst_valid, bus.inst, bus.inst_pc, e.inst, e.pc); end
        checks++; if (redirect_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL rr_cnt2: got %0d want %0d", redirect_cnt, exp_cnt); end
    endtask

    task automatic test_hold_redirect();
        exp_t e;
        do_reset();
        jump_to(32'h40);
        bus.imem_ack = 1'b1; bus.imem_rdata = pat(32'h40);
        exp_q.push_back('{inst: pat(32'h40), pc: 32'h40});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL hr_hold: got v=%0b pc=%h want v=1 pc=%h", bus.inst_valid, bus.inst_pc, e.pc); end
        bus.inst_ready = 1'b1;
        bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h200;
        @(negedge clk);
        exp_cnt++;
        drive_idle();
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("[TB] FAIL hr_addr: got req=%0b addr=%h want req=1 addr=200", bus.imem_req, bus.imem_addr); end
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL hr_valid: got %0b want 0", bus.inst_valid); end
        checks++; if (redirect_cnt !== 16'(exp_cnt)) begin errors++; $display("[TB] FAIL hr_cnt: got %0d want %0d", redirect_cnt, exp_cnt); end
        bus.imem_ack = 1'b1; bus.imem_rdata = pat(32'h200);
        exp_q.push_back('{inst: pat(32'h200), pc: 32'h200});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== e.inst || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL hr_fetch: got v=%0b %h@%h want v=1 %h@%h", bus.inst_valid, bus.inst, bus.inst_pc, e.inst, e.pc); end
    endtask

    task automatic test_not_taken();
        logic [31:0] exp_pc = 32'h0;
        exp_t        e;
        rstn = 1'b0;
        drive_idle();
        bus.br_valid = 1'b1; bus.br_taken = 1'b0; bus.br_target = 32'h888;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL nt_first: got req=%0b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        for (int c = 0; c < 60; c++) begin
            bus.br_target  = $urandom;
            bus.imem_ack   = 1'b0;
            bus.inst_ready = 1'($urandom_range(0, 1));
            if (bus.imem_req === 1'b1) begin
                checks++; if (bus.imem_addr !== exp_pc || bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL nt_req c=%0d: got addr=%h valid=%0b want addr=%h valid=0", c, bus.imem_addr, bus.inst_valid, exp_pc); end
                bus.imem_ack   = 1'($urandom_range(0, 1));
                bus.imem_rdata = $urandom;
                if (bus.imem_ack) exp_q.push_back('{inst: bus.imem_rdata, pc: exp_pc});
            end
            if (bus.inst_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("[TB] FAIL nt_unexpected c=%0d: inst_pc %h with nothing expected", c, bus.inst_pc);
                end else begin
                    e = exp_q[0];
                    if (bus.inst !== e.inst || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL nt_inst c=%0d: got %h@%h want %h@%h", c, bus.inst, bus.inst_pc, e.inst, e.pc); end
                    if (bus.inst_ready) begin
                        void'(exp_q.pop_front());
                        exp_pc += 32'd4;
                    end
                end
            end
            @(negedge clk);
        end
        checks++; if (redirect_cnt !== 16'h0) begin errors++; $display("[TB] FAIL nt_cnt: got %0d want 0", redirect_cnt); end
        drive_idle();
    endtask

    task automatic test_saturate_and_reset();
        exp_t e;
        do_reset();
        bus.imem_ack = 1'b0;
        bus.br_valid = 1'b1; bus.br_taken = 1'b1; bus.br_target = 32'h1000;
        for (int k = 1; k <= 65540; k++) begin
            @(negedge clk);
            if (k == 65534) begin
                checks++; if (redirect_cnt !== 16'hFFFE) begin errors++; $display("[TB] FAIL sat_near: got %h want fffe", redirect_cnt); end
            end
        end
        checks++; if (redirect_cnt !== 16'hFFFF) begin errors++; $display("[TB] FAIL sat_hold: got %h want ffff", redirect_cnt); end
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL sat_addr: got req=%0b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        // reset while a killed request is outstanding
        rstn = 1'b0;
        drive_idle();
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.inst_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_req_rst: got req=%0b addr=%h valid=%0b want 0/0/0", bus.imem_req, bus.imem_addr, bus.inst_valid); end
        checks++; if (bus.inst !== 32'h0 || bus.inst_pc !== 32'h0 || redirect_cnt !== 16'h0) begin errors++; $display("[TB] FAIL mid_req_rst_regs: got inst=%h pc=%h cnt=%h want 0", bus.inst, bus.inst_pc, redirect_cnt); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL post_rst_req: got req=%0b addr=%h want req=1 addr=0", bus.imem_req, bus.imem_addr); end
        bus.imem_ack = 1'b1; bus.imem_rdata = pat(32'h0);
        exp_q.push_back('{inst: pat(32'h0), pc: 32'h0});
        @(negedge clk);
        bus.imem_ack = 1'b0;
        e = exp_q.pop_front();
        checks++; if (bus.inst_valid !== 1'b1 || bus.inst !== e.inst || bus.inst_pc !== e.pc) begin errors++; $display("[TB] FAIL post_rst_fetch: got v=%0b %h@%h want v=1 %h@%h", bus.inst_valid, bus.inst, bus.inst_pc, e.inst, e.pc); end
        // reset while holding an instruction
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.inst !== 32'h0) begin errors++; $display("[TB] FAIL mid_hold_rst: got valid=%0b inst=%h want 0/0", bus.inst_valid, bus.inst); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1) begin errors++; $display("[TB] FAIL after_hold_rst: got valid=%0b req=%0b want 0/1", bus.inst_valid, bus.imem_req); end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_sequential();
        test_hold_stall();
        test_redirect_req();
        test_hold_redirect();
        test_not_taken();
        test_saturate_and_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; the PC value loaded on reset.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 imem_req  output  1  instruction-memory request valid.
REQ-005 imem_addr  output  32  fetch address, word aligned.
REQ-006 imem_ack  input  1  memory accepts the request and returns data in the same cycle.
REQ-007 imem_rdata  input  32  instruction word, valid when imem_ack=1.
REQ-008 inst_valid  output  1  a fetched instruction is offered downstream.
REQ-009 inst  output  32  the offered instruction.
REQ-010 inst_pc  output  32  the PC of the offered instruction.
REQ-011 inst_ready  input  1  downstream consumes the instruction when inst_valid=1.
REQ-012 br_valid  input  1  a branch or jump is resolved this cycle.
REQ-013 br_taken  input  1  the resolved branch is taken; qualified by br_valid.
REQ-014 br_target  input  32  the redirect address; qualified by br_valid and br_taken.
REQ-015 redirect_cnt  output  16  saturating count of taken redirects.

Function
REQ-016 The block SHALL use the states IDLE, REQ and HOLD, plus a 1-bit kill flag and a 32-bit pend_pc register.
REQ-017 A redirect SHALL mean br_valid=1 and br_taken=1; br_valid=1 with br_taken=0 SHALL have no effect.
REQ-018 The redirect target SHALL be {br_target[31:2],2'b00}, i.e. the low two bits are forced to zero.
REQ-019 IDLE: all outputs are inactive; the block SHALL move to REQ on the next cycle unconditionally.
REQ-020 REQ: imem_req=1 and imem_addr=pc, and both SHALL hold stable until imem_ack=1.
REQ-021 REQ, imem_ack=1, kill=0, no redirect: the block SHALL latch inst<=imem_rdata and inst_pc<=pc, then go to HOLD.
REQ-022 REQ, redirect, imem_ack=0: the block SHALL set kill=1 and pend_pc<=target, stay in REQ, and leave imem_addr unchanged.
- A later redirect while kill=1 SHALL overwrite pend_pc.
REQ-023 REQ, imem_ack=1 with kill=1 and/or a redirect in the same cycle: the returned data SHALL be discarded.
- pc SHALL become the same-cycle target if a redirect is present, otherwise pend_pc.
- kill SHALL clear, and the state SHALL remain REQ.
REQ-024 HOLD: inst_valid=1, and inst and inst_pc SHALL be stable; imem_req=0.
REQ-025 HOLD, inst_ready=1, no redirect: pc SHALL become pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0) and the state SHALL go to REQ.
REQ-026 HOLD with a redirect: the redirect SHALL win over inst_ready; the instruction is dropped, pc<=target, and the state SHALL go to REQ.
REQ-027 Latency: a fetch with imem_ack in its first REQ cycle SHALL yield inst_valid in the following cycle.
REQ-028 Throughput: at most one instruction per two cycles.
REQ-029 redirect_cnt SHALL increment by 1 on every redirect cycle in any state except IDLE, and saturate at 16'hFFFF.
REQ-030 inst_valid SHALL never be asserted for discarded data.

Reset
REQ-031 While rstn=0 at a clock edge, the block SHALL clear all state:
- state=IDLE, pc=RESET_PC, kill=0, pend_pc=0;
- imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, redirect_cnt=0.
REQ-032 Reset asserted mid-fetch or mid-HOLD SHALL abandon the transaction, with no inst_valid afterward until a new fetch completes.
REQ-033 The first imem_req SHALL appear in the second cycle after rstn returns high (one IDLE cycle, then REQ).

Verification
REQ-034 Reset release, ack always 1, ready always 1, RESET_PC=0 -> inst_pc sequence 0,4,8 on inst_valid in every other cycle.
REQ-035 HOLD at pc=0x10 with ready=0 for 3 cycles -> inst and inst_pc stable, imem_req=0; then ready=1 -> next imem_addr=0x14.
REQ-036 REQ at 0x20, ack=0, redirect to 0x103 -> imem_addr stays 0x20; ack next cycle is discarded; following request at 0x100; redirect_cnt=1.
REQ-037 HOLD with ready=1 and a same-cycle redirect to 0x200 -> instruction dropped, next imem_addr=0x200, no pc+4 fetch.
REQ-038 br_valid=1, br_taken=0 in every state -> behaviour identical to no branch; redirect_cnt unchanged.
REQ-039 Force redirect_cnt near 16'hFFFF via repeated redirects -> holds at 16'hFFFF; rstn=0 mid-REQ -> all outputs at reset values next cycle.
